// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: buffers host writes and issues one
// xmitH start pulse per frame, paced by xmit_doneH, with a busy-acknowledge timeout.
// Handshakes: a host byte is taken on any edge where wr_enH is high and the FIFO is
// not full (or is popping); a byte is issued to the transmitter by one xmitH cycle,
// after which xmit_doneH low means accepted and xmit_doneH high again means finished.
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic              wr_enH,
  input  logic [7:0]        wr_dataH,
  output logic              fullH,
  output logic              emptyH,
  output logic [ADDR_W:0]   countH,
  output logic              overflowH,
  input  logic              clr_ovfH,
  output logic              xmitH,
  output logic [7:0]        xmit_dataH,
  input  logic              xmit_doneH,
  output logic              tx_activeH,
  output logic              timeoutH,
  output logic [1:0]        fsmStateH
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0]     TMO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0]     TMO_ONE  = TW'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  state_t            state, nextState;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic [ADDR_W:0]   countNext;
  logic [TW-1:0]     tmoCnt;
  logic              pop, wrAcc, drop, tmoLoad, tmoInc;

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    timeoutH  = 1'b0;
    tmoLoad   = 1'b0;
    tmoInc    = 1'b0;
    case (state)
      IDLE: begin
        if (!emptyH && xmit_doneH) begin
          pop       = 1'b1;
          nextState = START;
        end
      end
      START: begin
        tmoLoad   = 1'b1;
        nextState = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!xmit_doneH) begin
          nextState = WAIT_DONE;
        end else if (tmoCnt == TMO_LAST) begin
          // Transmitter never acknowledged: the popped byte is dropped for good.
          timeoutH  = 1'b1;
          nextState = IDLE;
        end else begin
          tmoInc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (xmit_doneH) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign wrAcc = wr_enH && (!fullH || pop);
  assign drop  = wr_enH && fullH && !pop;

  always_comb begin
    countNext = countH;
    if (wrAcc && !pop)      countNext = countH + CNT_ONE;
    else if (pop && !wrAcc) countNext = countH - CNT_ONE;
  end

  assign xmitH      = (state == START);
  assign tx_activeH = (state != IDLE);
  assign fsmStateH  = state;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state      <= IDLE;
      wrPtr      <= '0;
      rdPtr      <= '0;
      countH     <= '0;
      fullH      <= 1'b0;
      emptyH     <= 1'b1;
      overflowH  <= 1'b0;
      xmit_dataH <= 8'h00;
      tmoCnt     <= '0;
    end else begin
      state  <= nextState;
      countH <= countNext;
      fullH  <= (countNext == CNT_FULL);
      emptyH <= (countNext == '0);
      if (wrAcc) wrPtr <= wrPtr + PTR_ONE;
      if (pop) begin
        rdPtr      <= rdPtr + PTR_ONE;
        xmit_dataH <= mem[rdPtr];
      end
      // A dropped write outranks a clear request in the same cycle.
      if (drop)          overflowH <= 1'b1;
      else if (clr_ovfH) overflowH <= 1'b0;
      if (tmoLoad)     tmoCnt <= '0;
      else if (tmoInc) tmoCnt <= tmoCnt + TMO_ONE;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge sys_clk) begin
    if (wrAcc) mem[wrPtr] <= wr_dataH;
  end

endmodule
